// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for stalls, flushes,
// halt drain, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             idex_dREN,
   input  logic [4:0]       idex_wsel,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             branch_taken,
   input  logic             jump_id,
   input  logic             halt_id,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              halted_q;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              dwait, load_use, flush_evt, stall_evt;

   assign dwait    = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                     ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      flush_evt   = 1'b0;
      if (!nRST) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
         {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
      end else if (state_q == HALTED) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end else if (dwait) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
         ifid_flush  = (state_q == DRAIN);
      end else if (state_q == DRAIN) begin
         // Nothing new enters ID; older instructions keep flowing out.
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end else if (branch_taken) begin
         pc_en      = ihit;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         flush_evt  = ihit;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (jump_id) begin
         pc_en      = ihit;
         ifid_flush = 1'b1;
         flush_evt  = ihit;
      end else if (!ihit) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (dwait)        state_d = DWAIT;
            else if (halt_id) state_d = DRAIN;
         end
         DWAIT: begin
            if (!dwait)       state_d = halt_id ? DRAIN : RUN;
         end
         DRAIN: begin
            if (memwb_halt)   state_d = HALTED;
         end
         default:             state_d = HALTED;
      endcase
   end

   assign stall_evt = ~pc_en & (state_q != HALTED);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= RUN;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == HALTED);
         if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign halted    = halted_q;
   assign state_o   = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, flushes, halt drain,
// reset and counter saturation (second instance with CNT_W=2).
module tb_pipeline_hazard_ctrl;

   logic CLK = 1'b0;
   logic nRST, ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
   logic [4:0] idex_wsel, ifid_rs, ifid_rt;
   logic branch_taken, jump_id, halt_id, memwb_halt;

   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic halted;
   logic [1:0] state_o;
   logic [15:0] stall_cnt, flush_cnt;

   logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush;
   logic s_halted;
   logic [1:0] s_state_o;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   logic [4:0] en;
   logic [3:0] fl;
   assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   assign fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

   int compared = 0;
   int mismatched = 0;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .branch_taken(branch_taken), .jump_id(jump_id),
      .halt_id(halt_id), .memwb_halt(memwb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .halted(halted), .state_o(state_o),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .branch_taken(branch_taken), .jump_id(jump_id),
      .halt_id(halt_id), .memwb_halt(memwb_halt),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
      .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush),
      .halted(s_halted), .state_o(s_state_o),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b1;
      exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
      idex_dREN = 1'b0; idex_wsel = 5'd0;
      ifid_rs = 5'd0; ifid_rt = 5'd0;
      branch_taken = 1'b0; jump_id = 1'b0;
      halt_id = 1'b0; memwb_halt = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 1'b0;
      step();
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 1'b0;
      #1;
      compared++; if (en !== 5'b00000) begin mismatched++; $display("FAIL rst_en got %b want 00000", en); end
      compared++; if (fl !== 4'b1111) begin mismatched++; $display("FAIL rst_fl got %b want 1111", fl); end
      step();
      compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL rst_state got %0d want 0", state_o); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL rst_halted got %b want 0", halted); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
      compared++; if (flush_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_flush got %0d want 0", flush_cnt); end
      nRST = 1'b1;
      #1;
      compared++; if (en !== 5'b11111) begin mismatched++; $display("FAIL dflt_en got %b want 11111", en); end
      compared++; if (fl !== 4'b0000) begin mismatched++; $display("FAIL dflt_fl got %b want 0000", fl); end
   endtask

   task automatic test_load_use();
      do_reset();
      idex_dREN = 1'b1; idex_wsel = 5'd3; ifid_rs = 5'd5; ifid_rt = 5'd3;
      #1;
      compared++; if (en !== 5'b00111) begin mismatched++; $display("FAIL lu_en got %b want 00111", en); end
      compared++; if (fl !== 4'b0100) begin mismatched++; $display("FAIL lu_fl got %b want 0100", fl); end
      step();
      idex_dREN = 1'b0;
      #1;
      compared++; if (en !== 5'b11111) begin mismatched++; $display("FAIL lu_next_en got %b want 11111", en); end
      compared++; if (fl !== 4'b0000) begin mismatched++; $display("FAIL lu_next_fl got %b want 0000", fl); end
      compared++; if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL lu_stall got %0d want 1", stall_cnt); end
      step();
      compared++; if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL lu_stall_hold got %0d want 1", stall_cnt); end
      idex_dREN = 1'b1; idex_wsel = 5'd5;
      #1;
      compared++; if (en !== 5'b00111) begin mismatched++; $display("FAIL lu_rs_en got %b want 00111", en); end
      idex_dREN = 1'b0;
   endtask

   task automatic test_zero_reg();
      do_reset();
      idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      #1;
      compared++; if (en !== 5'b11111) begin mismatched++; $display("FAIL zero_en got %b want 11111", en); end
      compared++; if (fl !== 4'b0000) begin mismatched++; $display("FAIL zero_fl got %b want 0000", fl); end
      step();
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL zero_stall got %0d want 0", stall_cnt); end
   endtask

   task automatic test_dwait();
      do_reset();
      exmem_dREN = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
      idex_dREN = 1'b1; idex_wsel = 5'd4; ifid_rt = 5'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++; if (en !== 5'b00001) begin mismatched++; $display("FAIL dw_en[%0d] got %b want 00001", i, en); end
         compared++; if (fl !== 4'b0001) begin mismatched++; $display("FAIL dw_fl[%0d] got %b want 0001", i, fl); end
         if (i > 0) begin
            compared++; if (state_o !== 2'd1) begin mismatched++; $display("FAIL dw_state[%0d] got %0d want 1", i, state_o); end
         end
         step();
      end
      compared++; if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL dw_stall got %0d want 3", stall_cnt); end
      dhit = 1'b1;
      #1;
      compared++; if (state_o !== 2'd1) begin mismatched++; $display("FAIL dw_hit_state got %0d want 1", state_o); end
      compared++; if (en !== 5'b11111) begin mismatched++; $display("FAIL dw_br_en got %b want 11111", en); end
      compared++; if (fl !== 4'b1100) begin mismatched++; $display("FAIL dw_br_fl got %b want 1100", fl); end
      compared++; if (flush_cnt !== 16'd0) begin mismatched++; $display("FAIL dw_flush0 got %0d want 0", flush_cnt); end
      step();
      idle_inputs();
      #1;
      compared++; if (flush_cnt !== 16'd1) begin mismatched++; $display("FAIL dw_flush1 got %0d want 1", flush_cnt); end
      compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL dw_run got %0d want 0", state_o); end
      compared++; if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL dw_stall_hold got %0d want 3", stall_cnt); end
   endtask

   task automatic test_branch_wait();
      do_reset();
      branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ihit = (i == 2);
         #1;
         compared++; if (fl !== 4'b1100) begin mismatched++; $display("FAIL br_fl[%0d] got %b want 1100", i, fl); end
         compared++; if (en !== {(i == 2), 4'b1111}) begin mismatched++; $display("FAIL br_en[%0d] got %b want %b", i, en, {(i == 2), 4'b1111}); end
         step();
      end
      idle_inputs();
      #1;
      compared++; if (flush_cnt !== 16'd1) begin mismatched++; $display("FAIL br_flush got %0d want 1", flush_cnt); end
      compared++; if (stall_cnt !== 16'd2) begin mismatched++; $display("FAIL br_stall got %0d want 2", stall_cnt); end
   endtask

   task automatic test_jump_fetch();
      do_reset();
      jump_id = 1'b1;
      #1;
      compared++; if (en !== 5'b11111) begin mismatched++; $display("FAIL jmp_en got %b want 11111", en); end
      compared++; if (fl !== 4'b1000) begin mismatched++; $display("FAIL jmp_fl got %b want 1000", fl); end
      step();
      jump_id = 1'b0; ihit = 1'b0;
      #1;
      compared++; if (flush_cnt !== 16'd1) begin mismatched++; $display("FAIL jmp_flush got %0d want 1", flush_cnt); end
      compared++; if (en !== 5'b01111) begin mismatched++; $display("FAIL fw_en got %b want 01111", en); end
      compared++; if (fl !== 4'b1000) begin mismatched++; $display("FAIL fw_fl got %b want 1000", fl); end
      ihit = 1'b1;
   endtask

   task automatic test_halt();
      do_reset();
      halt_id = 1'b1;
      #1;
      compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL ht_run got %0d want 0", state_o); end
      step();
      halt_id = 1'b0;
      for (int i = 0; i < 4; i++) begin
         memwb_halt = (i == 3);
         #1;
         compared++; if (state_o !== 2'd2) begin mismatched++; $display("FAIL ht_drain[%0d] got %0d want 2", i, state_o); end
         compared++; if ({pc_en, ifid_flush, idex_en} !== 3'b011) begin mismatched++; $display("FAIL ht_drain_ctl[%0d] got %b want 011", i, {pc_en, ifid_flush, idex_en}); end
         step();
      end
      memwb_halt = 1'b0;
      #1;
      compared++; if (state_o !== 2'd3) begin mismatched++; $display("FAIL ht_state got %0d want 3", state_o); end
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL ht_halted got %b want 1", halted); end
      compared++; if ({en, fl} !== 9'd0) begin mismatched++; $display("FAIL ht_outs got %b want 0", {en, fl}); end
      branch_taken = 1'b1; ihit = 1'b0; exmem_dREN = 1'b1; dhit = 1'b0;
      step();
      step();
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL ht_sticky got %b want 1", halted); end
      compared++; if ({en, fl} !== 9'd0) begin mismatched++; $display("FAIL ht_ignore got %b want 0", {en, fl}); end
      compared++; if (stall_cnt !== 16'd4) begin mismatched++; $display("FAIL ht_stall got %0d want 4", stall_cnt); end
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      idle_inputs();
      #1;
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL ht_rst_halted got %b want 0", halted); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL ht_rst_stall got %0d want 0", stall_cnt); end
      compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL ht_rst_state got %0d want 0", state_o); end
   endtask

   task automatic test_saturate();
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         compared++; if (s_stall_cnt !== sat_exp[i]) begin mismatched++; $display("FAIL sat2[%0d] got %0d want %0d", i, s_stall_cnt, sat_exp[i]); end
         compared++; if (stall_cnt !== 16'(i + 1)) begin mismatched++; $display("FAIL sat16[%0d] got %0d want %0d", i, stall_cnt, i + 1); end
      end
      ihit = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_dwait();
      test_branch_wait();
      test_jump_fetch();
      test_halt();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each cycle it decides the enable and flush for every stage register. Stalls cover instruction-memory wait, data-memory wait and load-use hazards. Flushes cover taken branches and jumps.
- It owns the halt drain sequence and keeps saturating stall/flush performance counters.
- Sits beside the datapath. Inputs come from the pipeline register outputs and the cache hit signals. Outputs drive each pipeline register's enable and flush.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- exmem_dREN  in  1  EX/MEM stage holds a load.
- exmem_dWEN  in  1  EX/MEM stage holds a store.
- idex_dREN  in  1  ID/EX stage holds a load.
- idex_wsel  in  5  destination register of the ID/EX instruction.
- ifid_rs  in  5  rs field of the IF/ID instruction.
- ifid_rt  in  5  rt field of the IF/ID instruction.
- branch_taken  in  1  branch resolved taken in EX.
- jump_id  in  1  J/JAL/JR decoded in ID.
- halt_id  in  1  HALT decoded in ID.
- memwb_halt  in  1  halt_out of the MEM/WB register.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero controls) on the next edge.
- halted  out  1  processor halted, sticky.
- state_o  out  2  current FSM state: 0 RUN, 1 DWAIT, 2 DRAIN, 3 HALTED.
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED.
- flush_cnt  out  CNT_W  branch/jump flush events.

Behaviour:
- Reset: the interface is fixed as one clock; reset is synchronous and active-low.
  - Sampled nRST=0 at an edge sets state to RUN and clears halted, stall_cnt and flush_cnt.
  - While nRST=0, outputs are forced: all enables 0, all flushes 1.
- Output timing:
  - Enables and flushes are combinational from the registered state plus the current inputs (zero latency).
  - halted is registered.
- Default (no condition active): all enables 1, all flushes 0.
- Priority, highest first:
  1. HALTED.
  2. Data wait.
  3. branch_taken.
  4. Load-use.
  5. jump_id.
  6. Fetch wait.
  7. Normal.
- Data wait, when (exmem_dREN|exmem_dWEN) & !dhit:
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_flush=1 (WB receives a bubble).
  - branch_taken, load-use and jump are ignored this cycle; they re-evaluate once dhit arrives.
- Load-use, when idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt):
  - pc_en=0, ifid_en=0, idex_flush=1.
  - Exactly one bubble, because the load advances to EX/MEM on the next edge.
- branch_taken:
  - ifid_flush=1, idex_flush=1.
  - pc_en=ihit, so the target is loaded when the fetch completes.
  - If !ihit, the flushes are still asserted every cycle until branch_taken drops.
- jump_id:
  - ifid_flush=1.
  - pc_en=ihit.
- Fetch wait (!ihit, no higher condition active):
  - pc_en=0.
  - ifid_flush=1, ifid_en=1 (bubble enters IF/ID).
  - Downstream stages advance.
- FSM transitions:
  - RUN→DWAIT when data wait is active; DWAIT→RUN on dhit.
  - Any state except HALTED →DRAIN when halt_id=1 and no data wait. Under data wait, halt_id is taken after dhit.
  - In DRAIN: pc_en=0 and ifid_flush=1 every cycle; stages behind ID drain normally, with data wait still honoured.
  - DRAIN→HALTED on memwb_halt=1.
- HALTED:
  - All enables 0, all flushes 0.
  - halted=1 from the edge after memwb_halt is sampled, held until reset.
  - All other inputs are ignored.
- Counters:
  - stall_cnt increments on each edge where pc_en=0 and state!=HALTED.
  - flush_cnt increments on each edge where branch_taken or jump_id wins priority and ihit=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Register $zero: idex_wsel=0 never produces a load-use stall.
- Reset mid-stall or mid-drain: state returns to RUN on that edge. Pipeline contents are the datapath's responsibility.

Test Plan:
- Load $3 in ID/EX (idex_dREN=1, idex_wsel=3), ifid_rt=3, ihit=dhit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle defaults; stall_cnt=1.
- Same as above with idex_wsel=0 -> no stall, pc_en=1.
- exmem_dREN=1, dhit=0 for 3 cycles while branch_taken=1 and a load-use match are also present -> 3 cycles of frozen enables with memwb_flush=1 and state_o=1; branch flush only after dhit.
- branch_taken=1 with ihit=0 for 2 cycles then 1 -> ifid_flush=idex_flush=1 for all 3 cycles; pc_en=0,0,1; flush_cnt=1.
- halt_id=1, then memwb_halt=1 four cycles later -> state_o=2 with ifid_flush=1 for 4 cycles, then state_o=3, halted=1 the following cycle and sticky; nRST=0 for one edge clears halted and counters.
- CNT_W=2, 5 fetch-wait cycles -> stall_cnt reads 1,2,3,3,3 (saturates).
